// File: rtl/tt_uart_pkg.sv
// tt_uart_pkg: shared UART state encoding, data width and parity helper for tx and rx
package tt_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int DATA_BITS = 8;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts CLKS_PER_BIT cycles per serial bit and flags the last one
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_done = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else cnt <= bit_done ? '0 : cnt + W'(1);
endmodule

// File: rtl/tt_result_uart_tx.sv
// tt_result_uart_tx: serialises result bytes as UART frames on a single idle-high pin
module tt_result_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);
  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("tt_result_uart_tx: CLKS_PER_BIT must be >=2 and STOP_BITS 1 or 2");
  end
  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           idx;
  logic                 par;
  logic                 stop_cnt;
  logic                 bit_done;
  // Timer is held at zero in IDLE so every bit starts a full period after acceptance
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .bit_done (bit_done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      idx      <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          state    <= START;
          tx       <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          shreg    <= in_data;
          par      <= even_parity(in_data);
        end
        START: if (bit_done) begin
          state <= DATA;
          tx    <= shreg[0];
          idx   <= '0;
        end
        DATA: if (bit_done) begin
          if (idx == 3'(DATA_BITS - 1)) begin
            state    <= PARITY_EN != 0 ? PARITY : STOP;
            tx       <= PARITY_EN != 0 ? par : 1'b1;
            stop_cnt <= 1'b0;
          end else begin
            idx   <= idx + 3'd1;
            shreg <= shreg >> 1;
            tx    <= shreg[1];
          end
        end
        PARITY: if (bit_done) begin
          state    <= STOP;
          tx       <= 1'b1;
          stop_cnt <= 1'b0;
        end
        STOP: if (bit_done) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else stop_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tt_result_uart_tx.sv
// tb_tt_result_uart_tx: directed frame checks across parity and stop-bit variants
module tb_tt_result_uart_tx;
  localparam int C = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [2:0] in_ready, tx, busy;
  int n_tot = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  tt_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]));
  tt_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]));
  tt_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  // Entered at the negedge of the first frame cycle; leaves at the negedge of the idle cycle after it
  task automatic check_frame(input int i, input logic [7:0] d, input int p, input int s, input bit noise);
    logic bits [12];
    int n;
    n = 1 + 8 + p + s;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1 + j] = d[j];
    for (int j = 9; j < 12; j++) bits[j] = 1'b1;
    if (p != 0) bits[9] = ^d;
    for (int k = 0; k < n * C; k++) begin
      check($sformatf("u%0d_%02h_tx_c%0d", i, d, k), 32'(tx[i]), 32'(bits[k / C]));
      check($sformatf("u%0d_%02h_busy_c%0d", i, d, k), 32'(busy[i]), 32'd1);
      check($sformatf("u%0d_%02h_rdy_c%0d", i, d, k), 32'(in_ready[i]), 32'd0);
      if (noise) begin
        in_valid = k[0];
        in_data = ~d;
      end
      @(negedge clk);
    end
    if (noise) in_valid = 1'b0;
    check($sformatf("u%0d_%02h_idle_tx", i, d), 32'(tx[i]), 32'd1);
    check($sformatf("u%0d_%02h_idle_busy", i, d), 32'(busy[i]), 32'd0);
    check($sformatf("u%0d_%02h_idle_rdy", i, d), 32'(in_ready[i]), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
      check($sformatf("rst_rdy%0d", i), 32'(in_ready[i]), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    send(8'hA5);
    check_frame(0, 8'hA5, 0, 1, 1'b0);
    do_reset();
    send(8'hA5);
    check_frame(1, 8'hA5, 1, 1, 1'b0);
    send(8'h07);
    check_frame(1, 8'h07, 1, 1, 1'b0);
    do_reset();
    send(8'h3C);
    check_frame(2, 8'h3C, 0, 2, 1'b0);
    do_reset();
    @(negedge clk);
    in_data = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hC3;
    check_frame(0, 8'h3C, 0, 1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(0, 8'hC3, 0, 1, 1'b0);
    do_reset();
    send(8'hF0);
    repeat (17) @(negedge clk);
    check("mid_bit3_tx", 32'(tx[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_rdy", 32'(in_ready[0]), 32'd1);
    rst_n = 1'b1;
    send(8'h55);
    check_frame(0, 8'h55, 0, 1, 1'b0);
    do_reset();
    send(8'h81);
    check_frame(0, 8'h81, 0, 1, 1'b1);
    @(negedge clk);
    check("no_late_accept", 32'(busy[0]), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
